div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/rv32_pkg.sv | 10 +
 rtl/div_step.sv | 22 ++
 rtl/div_unit.sv | 98 +++++++++
 tb/tb_div_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 width and M-extension divide op encodings
package rv32_pkg;
   localparam int xlen = 32;
   typedef enum logic [1:0] {
      op_div  = 2'b00,
      op_divu = 2'b01,
      op_rem  = 2'b10,
      op_remu = 2'b11
   } div_op_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in next dividend bit, trial subtract, keep or restore)
module div_step
   import rv32_pkg::*;
#(
   parameter int data_width = xlen
) (
   input  logic [data_width-1:0] rem,
   input  logic [data_width-1:0] quo,
   input  logic [data_width-1:0] dvs,
   output logic [data_width-1:0] rem_next,
   output logic [data_width-1:0] quo_next
);
   logic [data_width:0] shifted;
   logic [data_width:0] diff;
   // borrow out of the trial subtract means the divisor did not fit: restore and shift in 0
   always_comb begin
      shifted  = {rem, quo[data_width-1]};
      diff     = shifted - {1'b0, dvs};
      rem_next = diff[data_width] ? shifted[data_width-1:0] : diff[data_width-1:0];
      quo_next = {quo[data_width-2:0], ~diff[data_width]};
   end
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
module div_unit
   import rv32_pkg::*;
#(
   parameter int data_width = xlen
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic [1:0]            op_in,
   input  logic [data_width-1:0] a_in,
   input  logic [data_width-1:0] b_in,
   input  logic                  flush_in,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [data_width-1:0] res_out
);
   typedef enum logic [1:0] {idle, calc, fix, done} state_t;
   localparam logic [data_width-1:0] min_neg = {1'b1, {(data_width-1){1'b0}}};
   state_t                state;
   div_op_t               op_q;
   logic [data_width-1:0] quo, rem, dvs;
   logic                  neg_q, neg_r;
   logic [5:0]            cnt;
   logic [data_width-1:0] quo_step, rem_step;
   logic                  is_signed, a_neg, b_neg, special;
   logic [data_width-1:0] a_mag, b_mag, special_res, fixed_res;
   div_step #(.data_width(data_width)) u_step (
      .rem      (rem),
      .quo      (quo),
      .dvs      (dvs),
      .rem_next (rem_step),
      .quo_next (quo_step)
   );
   // operand decode: magnitudes, sign flags, divide-by-zero/overflow shortcut and final sign fix
   always_comb begin
      is_signed   = (op_in == op_div) || (op_in == op_rem);
      a_neg       = is_signed & a_in[data_width-1];
      b_neg       = is_signed & b_in[data_width-1];
      a_mag       = a_neg ? -a_in : a_in;
      b_mag       = b_neg ? -b_in : b_in;
      special     = ~|b_in || (is_signed && a_in == min_neg && &b_in);
      special_res = ~|b_in ? (op_in[1] ? a_in : {data_width{1'b1}}) : (op_in[1] ? '0 : min_neg);
      fixed_res   = (op_q == op_rem || op_q == op_remu) ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
   end
   // control FSM with registered busy/done/result; flush aborts silently and beats start
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state    <= idle;
         op_q     <= op_div;
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         cnt      <= '0;
         busy_out <= 1'b0;
         done_out <= 1'b0;
         res_out  <= '0;
      end else if (flush_in) begin
         state    <= idle;
         busy_out <= 1'b0;
         done_out <= 1'b0;
      end else begin
         case (state)
            idle: if (start_in) begin
               op_q     <= div_op_t'(op_in);
               quo      <= a_mag;
               rem      <= '0;
               dvs      <= b_mag;
               neg_q    <= a_neg ^ b_neg;
               neg_r    <= a_neg;
               cnt      <= 6'(data_width - 1);
               busy_out <= 1'b1;
               state    <= special ? done : calc;
               done_out <= special;
               if (special) res_out <= special_res;
            end
            calc: begin
               rem <= rem_step;
               quo <= quo_step;
               cnt <= cnt - 6'd1;
               if (cnt == 6'd0) state <= fix;
            end
            fix: begin
               res_out  <= fixed_res;
               done_out <= 1'b1;
               state    <= done;
            end
            done: begin
               busy_out <= 1'b0;
               done_out <= 1'b0;
               state    <= idle;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit results, latency, flush and reset behaviour
module tb_div_unit;
   import rv32_pkg::*;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        start_in = 1'b0;
   logic [1:0]  op_in = 2'b00;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        flush_in = 1'b0;
   logic        busy_out, done_out;
   logic [31:0] res_out;
   int          errors = 0;
   int          checks = 0;
   div_unit #(.data_width(32)) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .start_in (start_in),
      .op_in    (op_in),
      .a_in     (a_in),
      .b_in     (b_in),
      .flush_in (flush_in),
      .busy_out (busy_out),
      .done_out (done_out),
      .res_out  (res_out)
   );
   always #5 clk_in = ~clk_in;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // called at a negedge; starts an op, scrambles inputs afterwards, returns at a negedge in idle
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit poke);
      int n;
      start_in = 1'b1;
      op_in = op;
      a_in = a;
      b_in = b;
      @(negedge clk_in);
      start_in = 1'b0;
      op_in = ~op;
      a_in = $urandom;
      b_in = $urandom;
      n = 1;
      check({tag, " busy"}, 32'(busy_out), 32'd1);
      while (!done_out && n < 100) begin
         start_in = poke && n >= 3 && n <= 6;
         if (poke) a_in = $urandom;
         @(negedge clk_in);
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'(lat));
      check({tag, " res"}, res_out, exp);
      start_in = poke;
      @(negedge clk_in);
      start_in = 1'b0;
      check({tag, " done pulse"}, {30'd0, done_out, busy_out}, 32'd0);
   endtask
   initial begin
      int pulses;
      #2;
      check("reset busy", 32'(busy_out), 32'd0);
      check("reset done", 32'(done_out), 32'd0);
      check("reset res", res_out, 32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      run_op("divu 100/7", op_divu, 32'd100, 32'd7, 32'd14, 34, 1'b0);
      run_op("remu 100/7", op_remu, 32'd100, 32'd7, 32'd2, 34, 1'b0);
      run_op("div -7/2", op_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
      run_op("rem -7/2", op_rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
      run_op("rem 7/-2", op_rem, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0);
      run_op("divu 5/0", op_divu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
      run_op("rem 5/0", op_rem, 32'd5, 32'd0, 32'd5, 1, 1'b0);
      run_op("div -7/0", op_div, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
      run_op("remu 9/0", op_remu, 32'd9, 32'd0, 32'd9, 1, 1'b0);
      run_op("div ovf", op_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
      run_op("rem ovf", op_rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
      run_op("div min/1", op_div, 32'h8000_0000, 32'd1, 32'h8000_0000, 34, 1'b0);
      run_op("div min/2", op_div, 32'h8000_0000, 32'd2, 32'hC000_0000, 34, 1'b0);
      run_op("divu max/1", op_divu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b0);
      run_op("divu max/ovf", op_divu, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b0);
      run_op("rem -100/7", op_rem, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 1'b0);
      run_op("div -100/7", op_div, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 1'b0);
      start_in = 1'b1;
      op_in = op_divu;
      a_in = 32'd100;
      b_in = 32'd7;
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (9) @(negedge clk_in);
      flush_in = 1'b1;
      @(negedge clk_in);
      flush_in = 1'b0;
      check("flush busy", 32'(busy_out), 32'd0);
      check("flush done", 32'(done_out), 32'd0);
      check("flush res", res_out, 32'hFFFF_FFF2);
      run_op("after flush", op_divu, 32'd1000, 32'd10, 32'd100, 34, 1'b0);
      start_in = 1'b1;
      op_in = op_divu;
      a_in = 32'd100;
      b_in = 32'd7;
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (4) @(negedge clk_in);
      #1 rst_in = 1'b1;
      #1;
      check("midreset busy", 32'(busy_out), 32'd0);
      check("midreset done", 32'(done_out), 32'd0);
      check("midreset res", res_out, 32'd0);
      #1 rst_in = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk_in);
         if (done_out || busy_out) pulses++;
      end
      check("midreset no done", 32'(pulses), 32'd0);
      run_op("start ignored", op_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
      run_op("after ignore", op_remu, 32'd100, 32'd7, 32'd2, 34, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
